// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island constants: packet type codes, null packet, source indices.
package hdmi_packet_pkg;

   typedef enum logic [7:0] {
      PKT_NULL      = 8'h00,
      PKT_AUDIO     = 8'h02,
      IF_VENDOR     = 8'h81,
      IF_AVI        = 8'h82,
      IF_SPD        = 8'h83,
      IF_AUDIO_INFO = 8'h84,
      IF_MPEG       = 8'h85
   } pkt_type_e;

   localparam logic [23:0] NULL_HEADER = 24'h000000;
   localparam logic [55:0] NULL_SUB    = 56'h0;

   localparam int SRC_AUDIO    = 0;
   localparam int SRC_IF_FIRST = 1;
   localparam int MAX_SOURCES  = 8;

   // Index of the set bit in a one-hot vector; zero when the vector is empty.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < MAX_SOURCES; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Rotating search over InfoFrame sources 1..NUM_SOURCES-1, starting after ptr.
module round_robin_arbiter
   import hdmi_packet_pkg::*;
#(
   parameter int NUM_SOURCES = 4
) (
   input  logic [NUM_SOURCES-1:0] req,
   input  logic [2:0]             ptr,
   output logic [NUM_SOURCES-1:0] grant
);

   localparam logic [3:0] LAST = 4'(NUM_SOURCES - 1);

   logic [7:0] req_ext;
   logic [7:0] grant_ext;
   logic [3:0] start;
   logic [3:0] sum;
   logic       found;

   assign req_ext = 8'(req);

   // Index 0 is never part of the ring, so wrap goes LAST -> 1.
   always_comb begin
      grant_ext = 8'h00;
      found     = 1'b0;
      sum       = 4'd0;
      start     = {1'b0, ptr} + 4'd1;
      if (start > LAST || start == 4'd0) start = 4'(SRC_IF_FIRST);
      for (int k = 0; k < NUM_SOURCES - 1; k++) begin
         sum = start + 4'(k);
         if (sum > LAST) sum = sum - LAST;
         if (!found && req_ext[sum[2:0]]) begin
            grant_ext[sum[2:0]] = 1'b1;
            found               = 1'b1;
         end
      end
   end

   assign grant = grant_ext[NUM_SOURCES-1:0];

endmodule

// File: rtl/info_frame_scheduler.sv
// Fills data-island packet slots: audio source 0 has strict priority, InfoFrames
// are sent once per video frame in round-robin order, otherwise a null packet.
module info_frame_scheduler
   import hdmi_packet_pkg::*;
#(
   parameter int NUM_SOURCES    = 4,
   parameter bit OVERRUN_ENABLE = 1'b1
) (
   input  logic                                clk_pixel,
   input  logic                                reset,
   input  logic                                frame_start,
   input  logic                                packet_slot,
   input  logic [NUM_SOURCES-1:0]              req,
   input  logic [NUM_SOURCES-1:0][23:0]        header_in,
   input  logic [NUM_SOURCES-1:0][3:0][55:0]   sub_in,
   output logic [NUM_SOURCES-1:0]              ack,
   output logic [23:0]                         header,
   output logic [3:0][55:0]                    sub,
   output logic [2:0]                          grant_id,
   output logic                                grant_valid,
   output logic [NUM_SOURCES-1:0]              overrun
);

   localparam logic [NUM_SOURCES-1:0] IF_MASK   = {{(NUM_SOURCES-1){1'b1}}, 1'b0};
   localparam logic [2:0]             LAST_SRC  = 3'(NUM_SOURCES - 1);

   logic [NUM_SOURCES-1:0] due;
   logic [NUM_SOURCES-1:0] due_nxt;
   logic [2:0]             last_served;
   logic [NUM_SOURCES-1:0] rr_grant;
   logic [NUM_SOURCES-1:0] grant_vec;
   logic [NUM_SOURCES-1:0] slot_grant;
   logic                   any_grant;
   logic [2:0]             gid;
   logic [23:0]            sel_header;
   logic [3:0][55:0]       sel_sub;

   round_robin_arbiter #(.NUM_SOURCES(NUM_SOURCES)) u_rr (
      .req   (req & due & IF_MASK),
      .ptr   (last_served),
      .grant (rr_grant)
   );

   always_comb begin
      grant_vec = '0;
      if (req[SRC_AUDIO]) grant_vec[SRC_AUDIO] = 1'b1;
      else                grant_vec = rr_grant;
   end

   assign any_grant  = |grant_vec;
   assign gid        = onehot_to_idx(8'(grant_vec));
   assign slot_grant = packet_slot ? grant_vec : '0;

   always_comb begin
      sel_header = NULL_HEADER;
      sel_sub    = {4{NULL_SUB}};
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (grant_vec[i]) begin
            sel_header = header_in[i];
            sel_sub    = sub_in[i];
         end
      end
   end

   // frame_start re-arms every InfoFrame, even one granted in the same cycle.
   always_comb begin
      due_nxt = due & ~slot_grant;
      if (frame_start) due_nxt = IF_MASK;
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         due         <= '0;
         last_served <= LAST_SRC;
         header      <= NULL_HEADER;
         sub         <= {4{NULL_SUB}};
         grant_id    <= 3'd0;
         grant_valid <= 1'b0;
         ack         <= '0;
      end else begin
         due <= due_nxt;
         ack <= slot_grant;
         if (packet_slot) begin
            header      <= sel_header;
            sub         <= sel_sub;
            grant_id    <= gid;
            grant_valid <= any_grant;
            if (any_grant) last_served <= gid;
         end
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         overrun <= '0;
      end else if (OVERRUN_ENABLE && frame_start) begin
         overrun <= overrun | (due & IF_MASK & ~slot_grant);
      end
   end

endmodule
